// File: rtl/fd_delay_line_sched.sv
// Round-robin programming of shared-bus delay chips: grant, setup, latch-enable pulse, hold, one-cycle ack.
// Latency grant->ack = S+P+H cycles; requests wait (level req_i) while busy, no other backpressure.
module fd_delay_line_sched #(
    parameter int g_NUM_CHANNELS = 4,
    parameter int g_SETUP_CYCLES = 2,
    parameter int g_PULSE_CYCLES = 4,
    parameter int g_HOLD_CYCLES  = 2
) (
    input  logic                          clk_ref_i,
    input  logic                          rst_ref_i,
    input  logic [g_NUM_CHANNELS-1:0]     req_i,
    input  logic [10*g_NUM_CHANNELS-1:0]  delay_i,
    output logic [g_NUM_CHANNELS-1:0]     ack_o,
    output logic                          busy_o,
    output logic [9:0]                    dly_o,
    output logic [g_NUM_CHANNELS-1:0]     len_o
);

    generate
        if (g_NUM_CHANNELS < 1 || g_NUM_CHANNELS > 8) begin : g_bad_channels
            $error("g_NUM_CHANNELS must be 1..8");
        end
        if (g_SETUP_CYCLES < 1 || g_SETUP_CYCLES > 255) begin : g_bad_setup
            $error("g_SETUP_CYCLES must be 1..255");
        end
        if (g_PULSE_CYCLES < 1 || g_PULSE_CYCLES > 255) begin : g_bad_pulse
            $error("g_PULSE_CYCLES must be 1..255");
        end
        if (g_HOLD_CYCLES < 1 || g_HOLD_CYCLES > 255) begin : g_bad_hold
            $error("g_HOLD_CYCLES must be 1..255");
        end
    endgenerate

    localparam logic [7:0] SETUP_LD = 8'(g_SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LD = 8'(g_PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD  = 8'(g_HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_CH  = 3'(g_NUM_CHANNELS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, HOLD, ACK} state_t;

    state_t                    state, state_nxt;
    logic [7:0]                cnt, cnt_nxt;
    logic [2:0]                ch_idx, ch_nxt;
    logic [2:0]                rr_ptr, rr_nxt;
    logic [9:0]                dly_nxt;
    logic [g_NUM_CHANNELS-1:0] len_nxt, ack_nxt;
    logic                      busy_nxt;
    logic                      gnt_vld;
    logic [2:0]                gnt_idx;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin : arbiter
        int c;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c       = 0;
        for (int i = 0; i < g_NUM_CHANNELS; i++) begin
            c = int'(rr_ptr) + i;
            if (c >= g_NUM_CHANNELS) c = c - g_NUM_CHANNELS;
            for (int j = 0; j < g_NUM_CHANNELS; j++) begin
                if (j == c && !gnt_vld && req_i[j]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = 3'(j);
                end
            end
        end
    end

    always_ff @(posedge clk_ref_i) begin : state_reg
        if (rst_ref_i) begin
            state  <= IDLE;
            cnt    <= '0;
            ch_idx <= '0;
            rr_ptr <= '0;
            dly_o  <= '0;
            len_o  <= '1;
            ack_o  <= '0;
            busy_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ch_idx <= ch_nxt;
            rr_ptr <= rr_nxt;
            dly_o  <= dly_nxt;
            len_o  <= len_nxt;
            ack_o  <= ack_nxt;
            busy_o <= busy_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt = state;
        cnt_nxt   = cnt;
        ch_nxt    = ch_idx;
        rr_nxt    = rr_ptr;
        dly_nxt   = dly_o;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    state_nxt = SETUP;
                    cnt_nxt   = SETUP_LD;
                    ch_nxt    = gnt_idx;
                    for (int c = 0; c < g_NUM_CHANNELS; c++) begin
                        if (3'(c) == gnt_idx) dly_nxt = delay_i[c*10 +: 10];
                    end
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt = LOAD;
                    cnt_nxt   = PULSE_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            LOAD: begin
                if (cnt == 8'd0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LD;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) state_nxt = ACK;
                else             cnt_nxt   = cnt - 8'd1;
            end
            ACK: begin
                state_nxt = IDLE;
                rr_nxt    = (ch_idx == LAST_CH) ? 3'd0 : ch_idx + 3'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the next state so they land in registers.
    always_comb begin : outputs
        len_nxt  = '1;
        ack_nxt  = '0;
        busy_nxt = (state_nxt != IDLE);
        for (int c = 0; c < g_NUM_CHANNELS; c++) begin
            if (3'(c) == ch_nxt) begin
                len_nxt[c] = (state_nxt != LOAD);
                ack_nxt[c] = (state_nxt == ACK);
            end
        end
    end

endmodule

// File: tb/tb_fd_delay_line_sched.sv
// Randomized and directed bench for fd_delay_line_sched against a timestamp-based transaction model.
module tb_fd_delay_line_sched;
    localparam int N = 4;
    localparam int S = 2;
    localparam int P = 4;
    localparam int H = 2;
    localparam int T = S + P + H;

    logic          clk_ref = 1'b0;
    logic          rst_ref;
    logic [N-1:0]  req, ack, len;
    logic [10*N-1:0] delay;
    logic          busy;
    logic [9:0]    dly;

    logic [1:0]    req2, ack2, len2;
    logic [19:0]   delay2;
    logic          busy2;
    logic [9:0]    dly2;

    always #5 clk_ref = ~clk_ref;

    fd_delay_line_sched #(.g_NUM_CHANNELS(N), .g_SETUP_CYCLES(S),
                          .g_PULSE_CYCLES(P), .g_HOLD_CYCLES(H)) u_dut (
        .clk_ref_i(clk_ref), .rst_ref_i(rst_ref), .req_i(req), .delay_i(delay),
        .ack_o(ack), .busy_o(busy), .dly_o(dly), .len_o(len));

    fd_delay_line_sched #(.g_NUM_CHANNELS(2), .g_SETUP_CYCLES(1),
                          .g_PULSE_CYCLES(1), .g_HOLD_CYCLES(1)) u_fast (
        .clk_ref_i(clk_ref), .rst_ref_i(rst_ref), .req_i(req2), .delay_i(delay2),
        .ack_o(ack2), .busy_o(busy2), .dly_o(dly2), .len_o(len2));

    int checks = 0;
    int errors = 0;

    // Model: time of last grant, granted channel, sampled value, RR pointer.
    int         cyc   = 0;
    bit         m_act = 1'b0;
    int         m_gt  = 0;
    int         m_ch  = 0;
    int         m_rr  = 0;
    logic [9:0] m_dly = '0;
    logic [N-1:0] drop_on_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [9:0] slice(input logic [10*N-1:0] v, input int ch);
        return 10'(v >> (ch * 10));
    endfunction

    function automatic logic [10*N-1:0] set_slice(input logic [10*N-1:0] v, input int ch,
                                                  input logic [9:0] x);
        logic [10*N-1:0] m;
        m = {{(10*N-10){1'b0}}, 10'h3FF} << (ch * 10);
        return (v & ~m) | ({{(10*N-10){1'b0}}, x} << (ch * 10));
    endfunction

    task automatic check_cycle();
        int d;
        logic [N-1:0] e_len, e_ack;
        d     = cyc - m_gt;
        e_len = '1;
        e_ack = '0;
        if (m_act && d >= S && d < S + P) e_len[2'(m_ch)] = 1'b0;
        if (m_act && d == T)              e_ack[2'(m_ch)] = 1'b1;
        check("busy", 32'(busy), 32'(m_act && d <= T));
        check("len",  32'(len),  32'(e_len));
        check("ack",  32'(ack),  32'(e_ack));
        check("dly",  32'(dly),  32'(m_dly));
    endtask

    task automatic model_edge();
        int d;
        d = cyc - m_gt;
        if (rst_ref) begin
            m_act = 1'b0;
            m_rr  = 0;
            m_dly = '0;
        end else begin
            if (m_act && d == T) m_rr = (m_ch + 1) % N;
            if ((!m_act || d > T) && req != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (req[2'((m_rr + i) % N)]) begin
                        m_ch = (m_rr + i) % N;
                        break;
                    end
                end
                m_act = 1'b1;
                m_gt  = cyc + 1;
                m_dly = slice(delay, m_ch);
            end
        end
        cyc++;
    endtask

    task automatic tick();
        for (int c = 0; c < N; c++) begin
            if (ack[2'(c)] && drop_on_ack[2'(c)]) req[2'(c)] = 1'b0;
        end
        if (ack2[0]) req2[0] = 1'b0;
        model_edge();
        @(posedge clk_ref);
        @(negedge clk_ref);
        check_cycle();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || (m_act && cyc - m_gt <= T)) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) check("idle_timeout", 32'(n), 32'(0));
    endtask

    task automatic reset_pulse();
        rst_ref = 1'b1;
        tick();
        rst_ref = 1'b0;
    endtask

    task automatic observe(input int ch, output int first_low, output int low_cnt,
                           output int ack_off, output int dly_chg, output int other_low);
        logic [9:0] d0;
        logic [N-1:0] others;
        d0 = dly;
        first_low = -1; low_cnt = 0; ack_off = -1; dly_chg = 0; other_low = 0;
        for (int o = 0; o < T + 2; o++) begin
            others = len | (N'(1) << ch);
            if (others != '1) other_low++;
            if (len[2'(ch)] == 1'b0) begin
                if (first_low < 0) first_low = o;
                low_cnt++;
            end
            if (ack[2'(ch)] && ack_off < 0) ack_off = o;
            if (dly != d0) dly_chg++;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int fl, lc, ao, dc, ol, n;
        int order[$];
        int when[$];
        logic [9:0] dval[$];

        rst_ref = 1'b1; req = '0; req2 = '0; delay = '0; delay2 = '0; drop_on_ack = '1;
        @(negedge clk_ref);
        repeat (3) tick();
        check("rst_len",  32'(len),   32'(4'hF));
        check("rst_busy", 32'(busy),  32'(0));
        check("rst_dly",  32'(dly),   32'(0));
        check("rst_ack",  32'(ack),   32'(0));
        check("rst_len2", 32'(len2),  32'(2'b11));
        rst_ref = 1'b0;
        tick();

        // Single request on channel 0
        delay = set_slice(delay, 0, 10'h155);
        req   = 4'b0001;
        tick();
        check("single_dly", 32'(dly), 32'(10'h155));
        observe(0, fl, lc, ao, dc, ol);
        check("single_len_start", 32'(fl), 32'(2));
        check("single_len_cnt",   32'(lc), 32'(4));
        check("single_ack_off",   32'(ao), 32'(8));
        check("single_other_len", 32'(ol), 32'(0));
        wait_idle();

        // Round-robin across all four channels from a fresh pointer
        reset_pulse();
        delay = {10'd4, 10'd3, 10'd2, 10'd1};
        req   = '1;
        for (int i = 0; i < 45; i++) begin
            tick();
            for (int c = 0; c < N; c++) begin
                if (ack[2'(c)]) begin
                    order.push_back(c);
                    when.push_back(cyc);
                    dval.push_back(dly);
                end
            end
        end
        check("rr_count", 32'(order.size()), 32'(4));
        for (int i = 0; i < 4; i++) begin
            check("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i));
            check("rr_value", (i < dval.size()) ? 32'(dval[i]) : 32'hFFFF_FFFF, 32'(i + 1));
            if (i > 0)
                check("rr_spacing", (i < when.size()) ? 32'(when[i] - when[i-1]) : 32'hFFFF_FFFF,
                      32'(T + 2));
        end
        wait_idle();

        // Fairness: after serving ch2, ch3 precedes ch0
        req[2] = 1'b1;
        tick();
        wait_idle();
        order.delete();
        req[0] = 1'b1;
        req[3] = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            for (int c = 0; c < N; c++) if (ack[2'(c)]) order.push_back(c);
        end
        check("fair_first",  (order.size() > 0) ? 32'(order[0]) : 32'hFFFF_FFFF, 32'(3));
        check("fair_second", (order.size() > 1) ? 32'(order[1]) : 32'hFFFF_FFFF, 32'(0));
        wait_idle();

        // Delay value changes during SETUP are ignored
        delay = set_slice(delay, 1, 10'h010);
        req   = 4'b0010;
        tick();
        check("vc_dly_grant", 32'(dly), 32'(10'h010));
        delay = set_slice(delay, 1, 10'h3FF);
        observe(1, fl, lc, ao, dc, ol);
        check("vc_dly_stable", 32'(dc), 32'(0));
        check("vc_ack_off",    32'(ao), 32'(8));
        wait_idle();

        // Reset while ch1 latch enable is low, request kept high
        delay = set_slice(delay, 1, 10'h2C3);
        req   = 4'b0010;
        n = 0;
        while (len[1] !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("rml_len_low_timeout", 32'(n), 32'(0));
        rst_ref = 1'b1;
        tick();
        check("rml_len",  32'(len),  32'(4'hF));
        check("rml_dly",  32'(dly),  32'(0));
        check("rml_busy", 32'(busy), 32'(0));
        check("rml_ack",  32'(ack),  32'(0));
        rst_ref = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (ack[1]) begin
                n++;
                check("rml_dly_at_ack", 32'(dly), 32'(10'h2C3));
            end
            tick();
        end
        check("rml_reservice", 32'(n), 32'(1));
        wait_idle();

        // Minimum timing instance: S=P=H=1
        delay2 = {10'h000, 10'h2AA};
        req2   = 2'b01;
        tick();
        check("sw_dly", 32'(dly2), 32'(10'h2AA));
        fl = -1; lc = 0; ao = -1;
        for (int o = 0; o < 6; o++) begin
            if (len2[0] == 1'b0) begin
                if (fl < 0) fl = o;
                lc++;
            end
            if (len2[1] == 1'b0) check("sw_len1", 32'(len2[1]), 32'(1));
            if (ack2[0] && ao < 0) ao = o;
            tick();
        end
        check("sw_len_start", 32'(fl), 32'(1));
        check("sw_len_cnt",   32'(lc), 32'(1));
        check("sw_ack_off",   32'(ao), 32'(3));

        // Randomized traffic with early drops, held requests and stray resets
        for (int i = 0; i < 2000; i++) begin
            rst_ref = ($urandom_range(0, 499) == 0);
            for (int c = 0; c < N; c++) begin
                if (!req[2'(c)] && $urandom_range(0, 5) == 0) begin
                    req[2'(c)]         = 1'b1;
                    delay              = set_slice(delay, c, 10'($urandom));
                    drop_on_ack[2'(c)] = ($urandom_range(0, 3) != 0);
                end else if (req[2'(c)] && $urandom_range(0, 99) == 0) begin
                    req[2'(c)] = 1'b0;
                end
                if ($urandom_range(0, 9) == 0) delay = set_slice(delay, c, 10'($urandom));
            end
            tick();
        end
        rst_ref = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fd_delay_line_sched.md
Name: fd_delay_line_sched

Overview:
Schedules programming of g_NUM_CHANNELS MC100EP195-style programmable delay lines that share one 10-bit parallel delay bus, with a separate latch-enable line per chip. Requesters post a new tap value per channel; the block arbitrates round-robin, drives the shared bus, and pulses the selected chip's latch enable with programmable setup, pulse and hold times. It then acknowledges the requester. It sits between the per-channel timing/config logic and the FMC delay-chip pins.

Parameters:
g_NUM_CHANNELS, 4, number of delay chips/requesters (1..8)
g_SETUP_CYCLES, 2, cycles bus is stable before len goes low (1..255)
g_PULSE_CYCLES, 4, cycles len is held low (1..255)
g_HOLD_CYCLES, 2, cycles bus is held after len returns high (1..255)

Ports:
clk_ref_i  in  1  reference clock
rst_ref_i  in  1  synchronous reset, active-high
req_i  in  g_NUM_CHANNELS  per-channel update request, level; held until ack
delay_i  in  10*g_NUM_CHANNELS  packed tap values; channel n occupies bits [10n+9:10n]
ack_o  out  g_NUM_CHANNELS  one-cycle pulse: channel's value has been latched
busy_o  out  1  high whenever the FSM is not IDLE
dly_o  out  10  shared delay bus to all chips
len_o  out  g_NUM_CHANNELS  per-chip latch enable; 1 = latched/hold, 0 = transparent

Behaviour:
- Reset (sync, active-high): state IDLE, len_o all 1, dly_o 0, ack_o 0, busy_o 0, round-robin pointer 0, counter 0. Reset mid-operation aborts the cycle with no ack. len_o returns high on the reset edge. A requester still holding req_i is serviced after reset.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SETUP, LOAD, HOLD, ACK.
- IDLE: if any req_i bit is set at a clock edge, grant the first set bit at or after the RR pointer, searching upward with wrap. On that edge:
  - latch the granted channel index
  - load dly_o with that channel's delay_i slice
  - go to SETUP
  - the counter is loaded with g_SETUP_CYCLES-1.
- delay_i is sampled only at the grant edge. Later changes to delay_i are ignored for the current cycle.
- SETUP: lasts exactly g_SETUP_CYCLES cycles, then go to LOAD.
- LOAD: len_o of the granted channel is 0 for exactly g_PULSE_CYCLES cycles. Only one len_o bit is ever low at a time. On exit, len_o returns high.
- HOLD: lasts exactly g_HOLD_CYCLES cycles. dly_o is unchanged.
- ACK: ack_o of the granted channel is 1 for exactly one cycle. The RR pointer becomes granted index+1, wrapping to 0 after g_NUM_CHANNELS-1. Then go to IDLE.
- dly_o keeps its last value in IDLE. It changes only on a grant edge.
- Timing, with grant at edge k:
  - dly_o is valid from cycle k
  - len_o is low over cycles k+S .. k+S+P-1
  - ack_o is high in cycle k+S+P+H
  - S, P, H are the setup, pulse and hold parameters
  - defaults: len low cycles k+2..k+5, ack at k+8.
- Throughput: one update per S+P+H+2 cycles (10 cycles at defaults).
- Requester contract: req_i is dropped on the edge where ack_o is seen high. In that case the following IDLE does not re-grant it. If req_i stays high, it is treated as a new request and arbitrated normally behind other pending channels.
- A requester deasserting req_i before its ack does not abort an in-flight cycle. The cycle completes and ack_o still pulses.
- Simultaneous requests: the RR order guarantees each pending channel is served within g_NUM_CHANNELS cycles of updates.
- Counter width is 8 bits. Parameters outside range are an elaboration error (assertion).

Test Plan:
- Single request: reset, then req_i=0001 with delay_i[9:0]=10'h155. Expect:
  - dly_o=155 from the grant cycle
  - len_o[0]=0 for 4 cycles starting 2 cycles after grant
  - ack_o[0] high 8 cycles after grant
  - other len_o bits stay 1.
- Round-robin: req_i=1111 held with distinct values 1,2,3,4. Expect grants in order 0,1,2,3 at 10-cycle spacing, dly_o matching each. After each ack, drop that req; expect no repeats.
- Fairness after a serve: serve ch2, then raise ch0 and ch3 together. Expect ch3 granted before ch0.
- Value-change immunity: change delay_i[19:10] from 10'h010 to 10'h3FF during SETUP of ch1. Expect dly_o stays 010 throughout LOAD and HOLD.
- Reset mid-LOAD: assert rst_ref_i while len_o[1]=0. Expect:
  - next cycle len_o=all 1, dly_o=0, busy_o=0, no ack_o
  - with req_i[1] still high after reset, a full cycle for ch1 completes.
- Parameter sweep: run with S=1, P=1, H=1. Expect len_o low for exactly 1 cycle and ack 3 cycles after grant.
